input_debouncer: RTL and testbench

- Upstream conditioning stage for a raw, asynchronous, bouncy single-bit input (push-button or switch).
- Synchronises the input and filters bounce with a stability counter.
- Drives a clean level (`dout`) that feeds the single-bit input of the downstream logic block.
- Also provides one-cycle edge pulses and a rising-edge event counter for bring-up and observation.

---
 rtl/input_debouncer.sv | 78 +++++++
 tb/tb_input_debouncer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchroniser plus stability-counter debouncer with edge pulses and rise counter
// The debounced level only moves after the synchronised input has disagreed with it for STABLE_CYCLES edges.
module input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr_count,
    output logic             dout,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] event_count
);

    localparam int STAB_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [STAB_W-1:0]      stab_q, stab_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W-1:0]       evt_q, evt_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        stab_d = stab_q;
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        evt_d  = evt_q;
        if (s == dout_q) begin
            stab_d = '0;
        end else if (stab_q == STAB_LAST) begin
            dout_d = s;
            stab_d = '0;
            rise_d = s;
            fall_d = ~s;
        end else begin
            stab_d = stab_q + STAB_W'(1);
        end
        // A clear landing on the same edge as a rise wins; that rise is not counted.
        if (clr_count) begin
            evt_d = '0;
        end else if (rise_d) begin
            evt_d = evt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            stab_q <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            evt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            stab_q <= stab_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            evt_q  <= evt_d;
        end
    end

    assign dout        = dout_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign event_count = evt_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - table, directed and random checks of input_debouncer against a window model
module tb_input_debouncer;

    localparam int SYNC = 2;
    localparam int STAB = 16;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din = 1'b0;
    logic          clr_count = 1'b0;
    logic          dout, rise_pulse, fall_pulse;
    logic [CW-1:0] event_count;

    input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .clr_count(clr_count),
        .dout(dout), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .event_count(event_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int n_rise_seen = 0;
    int n_fall_seen = 0;

    // Model: s is din delayed SYNC edges; dout flips once the last STAB samples of s all disagree with it.
    bit            syncq[$];
    bit            win[$];
    logic          m_dout, m_rise, m_fall;
    logic [CW-1:0] m_cnt;

    task automatic model_reset();
        syncq.delete();
        for (int i = 0; i < SYNC; i++) syncq.push_back(1'b0);
        win.delete();
        m_dout = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_cnt = '0;
    endtask

    task automatic model_step();
        bit s, flip;
        s = syncq.pop_front();
        syncq.push_back(din);
        win.push_back(s);
        if (win.size() > STAB) void'(win.pop_front());
        flip = (win.size() == STAB);
        foreach (win[i]) if (win[i] == m_dout) flip = 1'b0;
        m_rise = flip && !m_dout;
        m_fall = flip && m_dout;
        if (flip) m_dout = ~m_dout;
        if (clr_count) m_cnt = '0;
        else if (m_rise) m_cnt = m_cnt + 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        if (rise_pulse === 1'b1) n_rise_seen++;
        if (fall_pulse === 1'b1) n_fall_seen++;
        check("outputs{dout,rise,fall,cnt}", {21'd0, dout, rise_pulse, fall_pulse, event_count},
              {21'd0, m_dout, m_rise, m_fall, m_cnt});
        check("pulse_exclusive", {31'd0, rise_pulse & fall_pulse}, 32'd0);
    endtask

    task automatic hold(input bit level, input int cycles);
        din = level;
        repeat (cycles) tick();
    endtask

    // Edges after the capture edge until dout reaches level; a clean step must take 17.
    task automatic step_latency(input bit level, input string name);
        int n;
        din = level;
        tick();
        n = 0;
        while (dout !== level && n < 100) begin
            tick();
            n++;
        end
        check(name, n, 17);
    endtask

    typedef struct {
        bit            d;
        bit            c;
        int            cyc;
        bit            e_dout;
        logic [CW-1:0] e_cnt;
    } seg_t;

    seg_t segs[6];
    int   r0, f0;

    initial begin
        segs[0] = '{1'b1, 1'b0, 10, 1'b0, 8'd1};
        segs[1] = '{1'b0, 1'b0, 30, 1'b0, 8'd1};
        segs[2] = '{1'b1, 1'b0, 15, 1'b0, 8'd1};
        segs[3] = '{1'b0, 1'b0, 30, 1'b0, 8'd1};
        segs[4] = '{1'b1, 1'b0, 16, 1'b0, 8'd1};
        segs[5] = '{1'b0, 1'b0, 40, 1'b0, 8'd2};

        // Reset and clean press
        model_reset();
        repeat (3) tick();
        check("reset_dout", {31'd0, dout}, 32'd0);
        check("reset_rise", {31'd0, rise_pulse}, 32'd0);
        check("reset_fall", {31'd0, fall_pulse}, 32'd0);
        check("reset_count", {24'd0, event_count}, 32'd0);
        rst_n = 1'b1;
        r0 = n_rise_seen;
        step_latency(1'b1, "clean_press_latency");
        hold(1'b1, 5);
        check("clean_press_rises", n_rise_seen - r0, 1);
        check("clean_press_count", {24'd0, event_count}, 32'd1);
        hold(1'b0, 40);

        // Glitch rejection and threshold boundary
        r0 = n_rise_seen;
        f0 = n_fall_seen;
        for (int i = 0; i < 4; i++) begin
            hold(segs[i].d, segs[i].cyc);
            check("glitch_seg_dout", {31'd0, dout}, {31'd0, segs[i].e_dout});
            check("glitch_seg_count", {24'd0, event_count}, {24'd0, segs[i].e_cnt});
        end
        check("glitch_no_pulses", (n_rise_seen - r0) + (n_fall_seen - f0), 0);
        for (int i = 4; i < 6; i++) begin
            clr_count = segs[i].c;
            hold(segs[i].d, segs[i].cyc);
            check("threshold_seg_dout", {31'd0, dout}, {31'd0, segs[i].e_dout});
            check("threshold_seg_count", {24'd0, event_count}, {24'd0, segs[i].e_cnt});
        end
        clr_count = 1'b0;

        // Bouncing press and release
        r0 = n_rise_seen;
        for (int i = 0; i < 10; i++) hold(((i % 2) == 0), 3);
        step_latency(1'b1, "bounce_press_latency");
        hold(1'b1, 20);
        check("bounce_press_rises", n_rise_seen - r0, 1);
        f0 = n_fall_seen;
        for (int i = 0; i < 10; i++) hold(((i % 2) != 0), 3);
        hold(1'b0, 40);
        check("bounce_release_falls", n_fall_seen - f0, 1);

        // Counter wrap
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        for (int i = 0; i < 256; i++) begin
            hold(1'b1, 20);
            hold(1'b0, 20);
            if (i == 254) check("wrap_count_255", {24'd0, event_count}, 32'd255);
        end
        check("wrap_count_0", {24'd0, event_count}, 32'd0);

        // Clear priority over a simultaneous rise
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 20);
            hold(1'b0, 20);
        end
        check("clear_pre_count", {24'd0, event_count}, 32'd5);
        din = 1'b1;
        tick();
        repeat (16) tick();
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("clear_edge_rise", {31'd0, rise_pulse}, 32'd1);
        check("clear_edge_count", {24'd0, event_count}, 32'd0);
        hold(1'b1, 5);
        hold(1'b0, 20);
        hold(1'b1, 20);
        check("clear_next_rise_count", {24'd0, event_count}, 32'd1);
        hold(1'b0, 20);

        // Reset in the middle of a stability count
        din = 1'b1;
        tick();
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_dout", {31'd0, dout}, 32'd0);
        check("async_reset_count", {24'd0, event_count}, 32'd0);
        check("async_reset_pulses", {30'd0, rise_pulse, fall_pulse}, 32'd0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        step_latency(1'b1, "post_reset_latency");
        hold(1'b1, 3);
        check("post_reset_count", {24'd0, event_count}, 32'd1);

        // Random bursts against the model
        for (int k = 0; k < 80; k++) begin
            din = $urandom_range(0, 1);
            repeat ($urandom_range(1, 24)) begin
                clr_count = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        clr_count = 1'b0;
        hold(1'b0, 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
